// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, sequential fetch stride and the
// fetch-stage FSM state type.
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush, simultaneous push/pop at any fill
// level (including full-with-pop) and an occupancy count; empty head reads 0.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_o != '0);
  assign do_push = push_i && ((count_o != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count_o <= count_o + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) mem[wr_ptr] <= data_i;
  end

  assign data_o = (count_o == '0) ? '0 : mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !flush_i && !pop_i && count_o == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && !flush_i && count_o == '0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited requests to a
// variable-latency memory and buffers {pc, instr} pairs for decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN            = cpu_pkg::XLEN,
  parameter int unsigned     INSTR_W         = cpu_pkg::INSTR_W,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(cpu_pkg::RESET_PC),
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    pc_o,
  input  logic               instr_ready_i
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1) + 1;

  fetch_state_t state;
  fetch_state_t state_next;

  logic [XLEN-1:0]         fetch_pc;
  logic [XLEN-1:0]         fetch_pc_next;
  logic [OW-1:0]           outstanding;
  logic [OW-1:0]           outstanding_next;
  logic [OW-1:0]           drop_cnt;
  logic [OW-1:0]           drop_cnt_next;
  logic [FW-1:0]           fifo_count;
  logic [OW-1:0]           tag_count;
  logic [XLEN-1:0]         rsp_pc;
  logic [XLEN+INSTR_W-1:0] head;
  logic [CW-1:0]           credit_used;

  logic gnt_fire;
  logic dropping;
  logic rsp_accept;
  logic tag_pop;
  logic pop_fire;

  // Credits count buffered entries plus live requests, so a response can
  // always be enqueued without back-pressuring the memory.
  assign credit_used = CW'(fifo_count) + CW'(outstanding) - CW'(drop_cnt);
  assign imem_req_o  = (state == RUN) && (outstanding < OW'(MAX_OUTSTANDING))
                       && (credit_used < CW'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc;

  assign gnt_fire   = imem_req_o && imem_gnt_i;
  assign dropping   = imem_rvalid_i && (drop_cnt != '0);
  assign rsp_accept = imem_rvalid_i && !dropping && !redirect_i;
  assign tag_pop    = rsp_accept && (tag_count != '0);

  assign instr_valid_o   = (fifo_count != '0);
  assign pop_fire        = instr_valid_o && instr_ready_i && !redirect_i;
  assign {pc_o, instr_o} = head;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i)  state_next = RUN;
      RUN:     if (!start_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A redirect overrides the sequential step and turns every request still
  // in flight after this cycle into one to be discarded.
  always_comb begin
    fetch_pc_next    = fetch_pc;
    outstanding_next = outstanding + OW'(gnt_fire) - OW'(imem_rvalid_i);
    drop_cnt_next    = drop_cnt - OW'(dropping);
    if (redirect_i) begin
      fetch_pc_next = {redirect_pc_i[XLEN-1:2], 2'b00};
      drop_cnt_next = outstanding_next;
    end else if (gnt_fire) begin
      fetch_pc_next = fetch_pc + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (gnt_fire),
    .data_i  (fetch_pc),
    .pop_i   (tag_pop),
    .data_o  (rsp_pc),
    .count_o (tag_count)
  );

  sync_fifo #(
    .WIDTH (XLEN + INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (rsp_accept),
    .data_i  ({rsp_pc, imem_rdata_i}),
    .pop_i   (pop_fire),
    .data_o  (head),
    .count_o (fifo_count)
  );

  a_outstanding_max: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding <= OW'(MAX_OUTSTANDING));
  a_drop_le_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    drop_cnt <= outstanding);
  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_rvalid_i && outstanding == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model with random latency feeds the
// DUT, and a PC-stream model of program order predicts what decode must see.
module tb_fetch_unit;

  localparam int unsigned MO  = 2;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_pc;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  req_t        pending[$];
  exp_t        sb[$];
  logic [31:0] seen_pc[$];
  logic [31:0] model_pc;
  int          epoch;
  int          cycle;
  int          tests;
  int          fails;
  int unsigned gnt_pct;
  int unsigned ready_pct;
  int unsigned resp_pct;

  fetch_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[17:2]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkSeen(input string name, input int idx, input logic [31:0] exp);
    if (idx < seen_pc.size()) begin
      checkOutput(name, {32'h0, seen_pc[idx]}, {32'h0, exp});
    end else begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: only %0d instructions delivered, expected pc %0h", name, seen_pc.size(), exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic redir, input logic [31:0] tgt);
    start_i       = start;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    instr_ready_i = ($urandom_range(99) < ready_pct);
    if (pending.size() != 0 && pending[0].due <= cycle && $urandom_range(99) < resp_pct) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pending[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
  endtask

  task automatic stepCycles(input int n, input logic start);
    repeat (n) begin
      @(negedge clk_i);
      applyStimulus(start, 1'b0, 32'h0);
    end
  endtask

  task automatic redirectCycle(input logic [31:0] tgt, input logic start);
    @(negedge clk_i);
    applyStimulus(start, 1'b1, tgt);
  endtask

  task automatic checkReset();
    checkOutput("rst_req", {63'h0, imem_req_o}, 64'h0);
    checkOutput("rst_valid", {63'h0, instr_valid_o}, 64'h0);
    checkOutput("rst_addr", {32'h0, imem_addr_o}, {32'h0, RPC});
    checkOutput("rst_instr", {32'h0, instr_o}, 64'h0);
    checkOutput("rst_pc", {32'h0, pc_o}, 64'h0);
  endtask

  task automatic drain();
    bit done;
    done      = 1'b0;
    ready_pct = 100;
    resp_pct  = 100;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_i);
      applyStimulus(1'b0, 1'b0, 32'h0);
      #3;
      done = (sb.size() == 0) && (pending.size() == 0) && !instr_valid_o;
    end
    checkOutput("drain_done", {63'h0, done}, 64'h1);
  endtask

  // Monitor: whenever decode takes the head, it must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i && instr_valid_o && instr_ready_i && !redirect_i) begin
        seen_pc.push_back(pc_o);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_output: got pc %0h with nothing expected", pc_o);
        end else begin
          e = sb.pop_front();
          checkOutput("out_pc", {32'h0, pc_o}, {32'h0, e.pc});
          checkOutput("out_instr", {32'h0, instr_o}, {32'h0, e.instr});
        end
      end
    end
  end

  // Memory and program-order model: grants carry the path epoch they were
  // issued on; only responses from the current epoch become expected output.
  initial begin
    req_t r;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i) begin
        pending.delete();
        sb.delete();
        model_pc = RPC;
        epoch++;
      end else begin
        if (imem_rvalid_i) begin
          r = pending.pop_front();
          if (r.epoch == epoch && !redirect_i)
            sb.push_back('{pc: r.exp_pc, instr: mem_word(r.exp_pc)});
        end
        if (imem_req_o && imem_gnt_i) begin
          checkOutput("req_addr", {32'h0, imem_addr_o}, {32'h0, model_pc});
          pending.push_back('{addr: imem_addr_o, exp_pc: model_pc, epoch: epoch, due: cycle + 1});
          model_pc = model_pc + 32'd4;
          checkOutput("outstanding_limit", {63'h0, pending.size() <= MO}, 64'h1);
        end
        if (redirect_i) begin
          epoch++;
          sb.delete();
          model_pc = {redirect_pc_i[31:2], 2'b00};
        end
      end
      cycle++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    epoch     = 0;
    cycle     = 0;
    model_pc  = RPC;
    gnt_pct   = 100;
    ready_pct = 100;
    resp_pct  = 100;
    rst_i     = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    stepCycles(3, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    #3;
    checkReset();

    // Streaming with one-cycle memory and an always-ready decoder.
    seen_pc.delete();
    stepCycles(20, 1'b1);
    checkSeen("stream_pc0", 0, 32'h0);
    checkSeen("stream_pc1", 1, 32'h4);
    checkSeen("stream_pc2", 2, 32'h8);
    drain();

    // Decoder stalled: buffer fills to depth and requests stop.
    ready_pct = 0;
    stepCycles(12, 1'b1);
    #3;
    checkOutput("stall_req", {63'h0, imem_req_o}, 64'h0);
    checkOutput("stall_valid", {63'h0, instr_valid_o}, 64'h1);
    checkOutput("stall_buffered", sb.size(), 64'd4);
    drain();

    // Redirect with two requests in flight.
    resp_pct = 0;
    stepCycles(5, 1'b1);
    #3;
    checkOutput("inflight_two", pending.size(), 64'd2);
    resp_pct = 100;
    redirectCycle(32'h0000_0103, 1'b1);
    @(negedge clk_i);
    checkOutput("redir_addr", {32'h0, imem_addr_o}, 64'h100);
    checkOutput("redir_valid", {63'h0, instr_valid_o}, 64'h0);
    seen_pc.delete();
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycles(20, 1'b1);
    checkSeen("redir_first_pc", 0, 32'h100);
    drain();

    // Redirect coinciding with a grant and a response in steady streaming.
    stepCycles(10, 1'b1);
    redirectCycle(32'h0000_0200, 1'b1);
    @(negedge clk_i);
    checkOutput("redir2_addr", {32'h0, imem_addr_o}, 64'h200);
    checkOutput("redir2_valid", {63'h0, instr_valid_o}, 64'h0);
    seen_pc.delete();
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycles(15, 1'b1);
    checkSeen("redir2_first_pc", 0, 32'h200);
    drain();

    // Redirect while idle to near the top of the address space: PC wraps.
    redirectCycle(32'hFFFF_FFFA, 1'b0);
    @(negedge clk_i);
    checkOutput("wrap_addr", {32'h0, imem_addr_o}, 64'hFFFF_FFF8);
    seen_pc.delete();
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycles(15, 1'b1);
    checkSeen("wrap_pc0", 0, 32'hFFFF_FFF8);
    checkSeen("wrap_pc1", 1, 32'hFFFF_FFFC);
    checkSeen("wrap_pc2", 2, 32'h0000_0000);
    checkSeen("wrap_pc3", 3, 32'h0000_0004);
    drain();

    // Stop mid-run with one request in flight, then reset.
    resp_pct = 0;
    stepCycles(2, 1'b1);
    gnt_pct = 0;
    stepCycles(1, 1'b0);
    gnt_pct = 100;
    stepCycles(3, 1'b0);
    #3;
    checkOutput("stop_req", {63'h0, imem_req_o}, 64'h0);
    checkOutput("stop_inflight", pending.size(), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    #3;
    checkReset();
    resp_pct = 100;
    seen_pc.delete();
    stepCycles(15, 1'b1);
    checkSeen("resume_pc0", 0, RPC);
    checkSeen("resume_pc1", 1, RPC + 32'd4);
    drain();

    // Random traffic: latency, back-pressure, start toggles and redirects.
    for (int blk = 0; blk < 6; blk++) begin
      gnt_pct   = $urandom_range(100, 30);
      ready_pct = $urandom_range(100, 20);
      resp_pct  = $urandom_range(100, 30);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_i);
        applyStimulus($urandom_range(99) < 93, $urandom_range(99) < 4, $urandom);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage, successor to the fixed PC register plus PC+4 adder of the single-cycle core. Owns the program counter and issues requests to a variable-latency instruction memory. Buffers returned instructions with their PCs in a prefetch FIFO and hands them to decode over a valid/ready handshake. Supports branch/jump redirect with flush and discards stale in-flight responses.

Parameters:
XLEN, 32, PC and address width
INSTR_W, 32, instruction width
RESET_PC, 0, PC loaded on reset
FIFO_DEPTH, 4, prefetch entries; power of two, at least 2
MAX_OUTSTANDING, 2, maximum granted-but-unreturned memory requests; at least 1

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
start_i  in  1  level; fetching permitted while high
redirect_i  in  1  one-cycle pulse; flush and restart at redirect_pc_i
redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored and forced to 0
imem_req_o  out  1  request valid
imem_addr_o  out  XLEN  request address
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid; responses return in order, at least 1 cycle after grant
imem_rdata_i  in  INSTR_W  response data
instr_valid_o  out  1  FIFO head valid
instr_o  out  INSTR_W  FIFO head instruction
pc_o  out  XLEN  FIFO head PC
instr_ready_i  in  1  decode accepts head

Behaviour:
- Clocking: single clock. Reset is synchronous and active-high.
- Reset values: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=IDLE. Outputs imem_req_o=0, instr_valid_o=0, imem_addr_o=RESET_PC, instr_o=0, pc_o=0.
- FSM IDLE: no requests issued. Moves to RUN when start_i=1.
- FSM RUN: moves back to IDLE when start_i=0. Requests already in flight still complete and are enqueued.
- Request condition: imem_req_o = RUN && outstanding < MAX_OUTSTANDING && (fifo_count + outstanding - drop_cnt) < FIFO_DEPTH. This credit rule means a response never finds the FIFO full.
- imem_addr_o always equals fetch_pc.
- On req && gnt: fetch_pc += 4 (wraps modulo 2^XLEN), outstanding += 1. A per-request PC tag queue of depth MAX_OUTSTANDING records the address.
- On rvalid: outstanding -= 1 and the tag is popped.
  - If drop_cnt>0: response discarded, drop_cnt -= 1.
  - Otherwise: {tag, rdata} is pushed to the FIFO.
- FIFO: pop when instr_valid_o && instr_ready_i. Push and pop in the same cycle are allowed at any count, including full-with-pop. Head is registered, so latency from rvalid to instr_valid_o is 1 cycle.
- Redirect (highest priority) in the cycle it is asserted:
  - FIFO flushed and tag queue cleared.
  - fetch_pc = {redirect_pc_i[XLEN-1:2], 2'b00}.
  - drop_cnt = outstanding (after counting this cycle's grant, minus this cycle's rvalid if not already dropped).
  - No push or pop takes effect; instr_valid_o=0 in the next cycle.
  - imem_req_o is still allowed in the redirect cycle, but uses the old fetch_pc; a grant in that cycle counts toward drop_cnt.
- Redirect while IDLE: PC and drop_cnt are updated and the FSM stays IDLE.
- Any reset mid-operation returns to the reset state. The instruction memory shares rst_i, so no response survives reset.
- Invariants: outstanding ≤ MAX_OUTSTANDING; drop_cnt ≤ outstanding; FIFO never overflows or underflows. Violations flagged by assertions.

Decomposition:
- Shared package cpu_pkg: XLEN, INSTR_W, PC_STEP (=4), RESET_PC default, and the fetch_state_t enum {IDLE, RUN}.
- One sub-module, sync_fifo: parametrised width/depth, synchronous flush, simultaneous push/pop, count output. Instantiated for the prefetch buffer (width XLEN+INSTR_W) and for the PC tag queue (width XLEN, depth MAX_OUTSTANDING).

Test Plan:
1. Reset then start_i=1, memory grants every cycle with 1-cycle latency, ready=1 → instr_valid_o from cycle 3; pc_o sequence 0x0, 0x4, 0x8, …; at most 2 outstanding.
2. Ready=0 held, zero-latency grants → exactly FIFO_DEPTH=4 instructions buffered; imem_req_o drops to 0 once count+outstanding=4; releasing ready drains PCs 0x0–0xC in order with no loss.
3. Two outstanding requests, redirect_i with redirect_pc_i=0x103 → next fetch address 0x100; both stale responses discarded; first pc_o after redirect = 0x100.
4. redirect_i asserted in the same cycle as rvalid and as a gnt → that response dropped, drop_cnt counts the granted request; no instruction from the old path ever appears at pc_o.
5. RESET_PC=0xFFFFFFF8, run 4 fetches → pc_o sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
6. start_i deasserted mid-run, then rst_i pulsed with outstanding=1 → no new requests after start_i falls; after reset all outputs at reset values, instr_valid_o=0, fetch resumes at RESET_PC on the next start_i.
